// File: rtl/seq_detector_compare.sv
// Lockstep Mealy/Moore detectors for one programmable bit pattern. Both machines
// share a generated next-state table, count their hits, and are cross-checked
// every cycle. Any disagreement sets a sticky error flag.
module seq_detector_compare #(
  parameter int                 SEQ_LEN = 4,
  parameter logic [SEQ_LEN-1:0] PATTERN = 4'b1011,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 CNT_W   = 8,
  localparam int                SW      = $clog2(SEQ_LEN + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             data_valid,
  input  logic             data_in,
  output logic             z_mealy,
  output logic             z_moore,
  output logic [SW-1:0]    state_mealy,
  output logic [SW-1:0]    state_moore,
  output logic [CNT_W-1:0] mealy_count,
  output logic [CNT_W-1:0] moore_count,
  output logic             agree,
  output logic             error
);

  if (SEQ_LEN < 2 || SEQ_LEN > 16) begin : g_len_check
    $error("seq_detector_compare: SEQ_LEN must be in 2..16");
  end

  // Pattern bit i in arrival order; PATTERN's MSB is received first.
  function automatic int pat_bit(input int i);
    return int'(PATTERN[SEQ_LEN-1-i]);
  endfunction

  // Length of the longest proper border of the whole pattern.
  function automatic int border_len();
    int best;
    bit ok;
    best = 0;
    for (int k = 1; k < SEQ_LEN; k++) begin
      ok = 1'b1;
      for (int i = 0; i < k; i++) begin
        if (pat_bit(i) != pat_bit(SEQ_LEN - k + i)) ok = 1'b0;
      end
      if (ok) best = k;
    end
    return best;
  endfunction

  // Longest suffix of prefix(s) followed by b that is also a pattern prefix.
  // A result of SEQ_LEN means the pattern has just completed.
  function automatic int raw_next(input int s, input int b);
    int best;
    int c;
    bit ok;
    best = 0;
    for (int k = 1; k <= s + 1; k++) begin
      if (k <= SEQ_LEN) begin
        ok = 1'b1;
        for (int i = 0; i < k; i++) begin
          c = (s + 1 - k + i == s) ? b : pat_bit(s + 1 - k + i);
          if (c != pat_bit(i)) ok = 1'b0;
        end
        if (ok) best = k;
      end
    end
    return best;
  endfunction

  localparam int N_ENT = 2 * (SEQ_LEN + 1);
  localparam int FB_I  = OVERLAP ? border_len() : 0;

  // Entry (2*s + b) is the raw successor of state s on bit b. The detected
  // state SEQ_LEN continues from the fallback state, exactly as the Mealy
  // machine does after it reports a hit.
  function automatic logic [N_ENT*SW-1:0] build_tbl();
    logic [N_ENT*SW-1:0] t;
    int f;
    t = '0;
    for (int s = 0; s <= SEQ_LEN; s++) begin
      for (int b = 0; b < 2; b++) begin
        f = (s == SEQ_LEN) ? raw_next(FB_I, b) : raw_next(s, b);
        t[(2*s+b)*SW +: SW] = SW'(f);
      end
    end
    return t;
  endfunction

  localparam logic [N_ENT*SW-1:0] NEXT_TBL = build_tbl();
  localparam logic [SW-1:0]       FULL     = SW'(SEQ_LEN);
  localparam logic [SW-1:0]       LAST     = SW'(SEQ_LEN - 1);
  localparam logic [SW-1:0]       FB       = SW'(FB_I);
  localparam logic [CNT_W-1:0]    CNT_MAX  = {CNT_W{1'b1}};

  logic [SW-1:0]    state_mealy_q, state_moore_q;
  logic [SW-1:0]    mealy_step, moore_step;
  logic [SW-1:0]    mealy_nxt, moore_nxt;
  logic             mealy_hit_q, moore_hit;
  logic [CNT_W-1:0] mealy_cnt_q, moore_cnt_q;
  logic             error_q;
  int               idx_me, idx_mo;

  // Next-state lookup for both machines plus the combinational hit terms.
  always_comb begin
    idx_me     = int'({state_mealy_q, data_in});
    idx_mo     = int'({state_moore_q, data_in});
    mealy_step = NEXT_TBL[idx_me*SW +: SW];
    moore_step = NEXT_TBL[idx_mo*SW +: SW];
    mealy_nxt  = (mealy_step == FULL) ? FB : mealy_step;
    moore_nxt  = moore_step;
    z_mealy    = data_valid && (state_mealy_q == LAST) && (data_in == PATTERN[0]);
    moore_hit  = data_valid && (moore_step == FULL);
  end

  // State, hit history, saturating counters and the sticky mismatch flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_mealy_q <= '0;
      state_moore_q <= '0;
      mealy_hit_q   <= 1'b0;
      mealy_cnt_q   <= '0;
      moore_cnt_q   <= '0;
      error_q       <= 1'b0;
    end else if (clear) begin
      state_mealy_q <= '0;
      state_moore_q <= '0;
      mealy_hit_q   <= 1'b0;
      mealy_cnt_q   <= '0;
      moore_cnt_q   <= '0;
      error_q       <= 1'b0;
    end else begin
      if (data_valid) begin
        state_mealy_q <= mealy_nxt;
        state_moore_q <= moore_nxt;
        mealy_hit_q   <= z_mealy;
        if (z_mealy && mealy_cnt_q != CNT_MAX) mealy_cnt_q <= mealy_cnt_q + 1'b1;
        if (moore_hit && moore_cnt_q != CNT_MAX) moore_cnt_q <= moore_cnt_q + 1'b1;
      end
      if (!agree) error_q <= 1'b1;
    end
  end

  assign z_moore     = (state_moore_q == FULL);
  assign agree       = (mealy_hit_q == z_moore);
  assign state_mealy = state_mealy_q;
  assign state_moore = state_moore_q;
  assign mealy_count = mealy_cnt_q;
  assign moore_count = moore_cnt_q;
  assign error       = error_q;

endmodule

// File: tb/tb_seq_detector_compare.sv
// Directed bench for seq_detector_compare: three instances (default, no-overlap,
// all-ones with 2-bit counters) share stimulus; a queue of expected per-cycle
// observations is drained by a monitor sampling on the falling edge.
module tb_seq_detector_compare;

  logic clk = 1'b0;
  logic reset, clear, data_valid, data_in;

  logic       zme_w [3];
  logic       zmo_w [3];
  logic [2:0] sme_w [3];
  logic [2:0] smo_w [3];
  logic       agr_w [3];
  logic       err_w [3];
  logic [7:0] mc0, oc0, mc1, oc1;
  logic [1:0] mc2, oc2;

  always #5 clk = ~clk;

  seq_detector_compare u_def (
    .clk(clk), .reset(reset), .clear(clear), .data_valid(data_valid), .data_in(data_in),
    .z_mealy(zme_w[0]), .z_moore(zmo_w[0]), .state_mealy(sme_w[0]), .state_moore(smo_w[0]),
    .mealy_count(mc0), .moore_count(oc0), .agree(agr_w[0]), .error(err_w[0]));

  seq_detector_compare #(.SEQ_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_novl (
    .clk(clk), .reset(reset), .clear(clear), .data_valid(data_valid), .data_in(data_in),
    .z_mealy(zme_w[1]), .z_moore(zmo_w[1]), .state_mealy(sme_w[1]), .state_moore(smo_w[1]),
    .mealy_count(mc1), .moore_count(oc1), .agree(agr_w[1]), .error(err_w[1]));

  seq_detector_compare #(.SEQ_LEN(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .CNT_W(2)) u_ones (
    .clk(clk), .reset(reset), .clear(clear), .data_valid(data_valid), .data_in(data_in),
    .z_mealy(zme_w[2]), .z_moore(zmo_w[2]), .state_mealy(sme_w[2]), .state_moore(smo_w[2]),
    .mealy_count(mc2), .moore_count(oc2), .agree(agr_w[2]), .error(err_w[2]));

  typedef struct {
    string tag;
    int    sel;
    int    zme, zmo, sme, smo, mc, oc, agr, err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  task automatic cmp(input string tag, input string fld, input int got, input int want);
    checks++;
    if (got == want) passes++;
    else $display("FAIL %s.%s got %0d expected %0d", tag, fld, got, want);
  endtask

  task automatic chk(input string tag, input int sel, input int zme, input int zmo,
                     input int sme, input int smo, input int mc, input int oc,
                     input int agr, input int err);
    exp_t e;
    e.tag = tag; e.sel = sel;
    e.zme = zme; e.zmo = zmo; e.sme = sme; e.smo = smo;
    e.mc = mc; e.oc = oc; e.agr = agr; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input logic v, input logic d, input logic c, input logic r);
    @(posedge clk);
    #1;
    data_valid = v;
    data_in    = d;
    clear      = c;
    reset      = r;
  endtask

  exp_t m;
  int   g_mc, g_oc;

  // Monitor: one expected observation per checked cycle, taken mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        m = exp_q.pop_front();
        case (m.sel)
          0:       begin g_mc = int'(mc0); g_oc = int'(oc0); end
          1:       begin g_mc = int'(mc1); g_oc = int'(oc1); end
          default: begin g_mc = int'(mc2); g_oc = int'(oc2); end
        endcase
        cmp(m.tag, "z_mealy",     int'(zme_w[m.sel]), m.zme);
        cmp(m.tag, "z_moore",     int'(zmo_w[m.sel]), m.zmo);
        cmp(m.tag, "state_mealy", int'(sme_w[m.sel]), m.sme);
        cmp(m.tag, "state_moore", int'(smo_w[m.sel]), m.smo);
        cmp(m.tag, "mealy_count", g_mc, m.mc);
        cmp(m.tag, "moore_count", g_oc, m.oc);
        cmp(m.tag, "agree",       int'(agr_w[m.sel]), m.agr);
        cmp(m.tag, "error",       int'(err_w[m.sel]), m.err);
      end
    end
  end

  initial begin
    reset = 1'b0; clear = 1'b0; data_valid = 1'b0; data_in = 1'b0;
    chk("reset", 0, 0,0,0,0,0,0,1,0);
    #12;
    cyc(0,0,0,1); chk("release", 0, 0,0,0,0,0,0,1,0);

    // Overlapping stream 1,0,1,1,0,1,1 on the default instance.
    cyc(1,1,0,1); chk("ovl_s1", 0, 0,0,0,0,0,0,1,0);
    cyc(1,0,0,1); chk("ovl_s2", 0, 0,0,1,1,0,0,1,0);
    cyc(1,1,0,1); chk("ovl_s3", 0, 0,0,2,2,0,0,1,0);
    cyc(1,1,0,1); chk("ovl_s4", 0, 1,0,3,3,0,0,1,0);
    cyc(1,0,0,1); chk("ovl_s5", 0, 0,1,1,4,1,1,1,0);
    cyc(1,1,0,1); chk("ovl_s6", 0, 0,0,2,2,1,1,1,0);
    cyc(1,1,0,1); chk("ovl_s7", 0, 1,0,3,3,1,1,1,0);
    cyc(0,0,0,1); chk("ovl_end", 0, 0,1,1,4,2,2,1,0);

    // Same stream, non-overlapping instance.
    cyc(0,0,1,1);
    cyc(1,1,0,1); chk("novl_s1", 1, 0,0,0,0,0,0,1,0);
    cyc(1,0,0,1); chk("novl_s2", 1, 0,0,1,1,0,0,1,0);
    cyc(1,1,0,1); chk("novl_s3", 1, 0,0,2,2,0,0,1,0);
    cyc(1,1,0,1); chk("novl_s4", 1, 1,0,3,3,0,0,1,0);
    cyc(1,0,0,1); chk("novl_s5", 1, 0,1,0,4,1,1,1,0);
    cyc(1,1,0,1); chk("novl_s6", 1, 0,0,0,0,1,1,1,0);
    cyc(1,1,0,1); chk("novl_s7", 1, 0,0,1,1,1,1,1,0);
    cyc(0,0,0,1); chk("novl_end", 1, 0,0,1,1,1,1,1,0);

    // Gapped valid 1,0,0 around 1,0,1,1; data_in wiggles during gaps.
    cyc(0,0,1,1);
    cyc(1,1,0,1); chk("gap_c1", 0, 0,0,0,0,0,0,1,0);
    cyc(0,1,0,1); chk("gap_c2", 0, 0,0,1,1,0,0,1,0);
    cyc(0,0,0,1); chk("gap_c3", 0, 0,0,1,1,0,0,1,0);
    cyc(1,0,0,1); chk("gap_c4", 0, 0,0,1,1,0,0,1,0);
    cyc(0,1,0,1); chk("gap_c5", 0, 0,0,2,2,0,0,1,0);
    cyc(0,1,0,1); chk("gap_c6", 0, 0,0,2,2,0,0,1,0);
    cyc(1,1,0,1); chk("gap_c7", 0, 0,0,2,2,0,0,1,0);
    cyc(0,1,0,1); chk("gap_c8", 0, 0,0,3,3,0,0,1,0);
    cyc(0,1,0,1); chk("gap_c9", 0, 0,0,3,3,0,0,1,0);
    cyc(1,1,0,1); chk("gap_c10", 0, 1,0,3,3,0,0,1,0);
    cyc(0,0,0,1); chk("gap_c11", 0, 0,1,1,4,1,1,1,0);
    cyc(0,1,0,1); chk("gap_c12", 0, 0,1,1,4,1,1,1,0);

    // All-ones pattern with 2-bit counters: four hits saturate at 3.
    cyc(0,0,1,1);
    cyc(1,1,0,1); chk("sat_s1", 2, 0,0,0,0,0,0,1,0);
    cyc(1,1,0,1); chk("sat_s2", 2, 0,0,1,1,0,0,1,0);
    cyc(1,1,0,1); chk("sat_s3", 2, 0,0,2,2,0,0,1,0);
    cyc(1,1,0,1); chk("sat_s4", 2, 1,0,3,3,0,0,1,0);
    cyc(1,1,0,1); chk("sat_s5", 2, 1,1,3,4,1,1,1,0);
    cyc(1,1,0,1); chk("sat_s6", 2, 1,1,3,4,2,2,1,0);
    cyc(1,1,0,1); chk("sat_s7", 2, 1,1,3,4,3,3,1,0);
    cyc(0,0,0,1); chk("sat_end", 2, 0,1,3,4,3,3,1,0);

    // Forced Moore mismatch, then clear together with a valid sample.
    cyc(0,0,1,1);
    cyc(1,1,0,1); chk("frc_s1", 0, 0,0,0,0,0,0,1,0);
    cyc(1,0,0,1); chk("frc_s2", 0, 0,0,1,1,0,0,1,0);
    cyc(1,1,0,1); chk("frc_s3", 0, 0,0,2,2,0,0,1,0);
    cyc(1,1,0,1); chk("frc_s4", 0, 1,0,3,3,0,0,1,0);
    cyc(0,0,0,1); chk("frc_hit", 0, 0,1,1,4,1,1,1,0);
    cyc(0,0,0,1);
    force u_def.state_moore_q = 3'd0;
    chk("frc_drop", 0, 0,0,1,0,1,1,0,0);
    cyc(0,0,0,1); chk("frc_latch", 0, 0,0,1,0,1,1,0,1);
    cyc(1,1,1,1);
    release u_def.state_moore_q;
    cyc(0,0,0,1); chk("frc_clear", 0, 0,0,0,0,0,0,1,0);

    // Asynchronous reset in mid-pattern, then a lone 1.
    cyc(0,0,1,1);
    cyc(1,1,0,1); chk("rst_s1", 0, 0,0,0,0,0,0,1,0);
    cyc(1,0,0,1); chk("rst_s2", 0, 0,0,1,1,0,0,1,0);
    cyc(1,1,0,1); chk("rst_s3", 0, 0,0,2,2,0,0,1,0);
    cyc(1,1,0,1); chk("rst_s4", 0, 1,0,3,3,0,0,1,0);
    cyc(1,1,0,1); chk("rst_s5", 0, 0,1,1,4,1,1,1,0);
    cyc(1,0,0,1); chk("rst_s6", 0, 0,0,1,1,1,1,1,0);
    cyc(1,1,0,1); chk("rst_s7", 0, 0,0,2,2,1,1,1,0);
    cyc(0,0,0,0); chk("rst_on", 0, 0,0,0,0,0,0,1,0);
    cyc(1,1,0,1); chk("rst_off", 0, 0,0,0,0,0,0,1,0);
    cyc(0,0,0,1); chk("rst_after", 0, 0,0,1,1,0,0,1,0);

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain pending %0d expected 0", exp_q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
